// File: rtl/loa_error_monitor.sv
// Error-statistics monitor for a lower-part-OR approximate adder: recomputes the exact sum per sample
// and accumulates error count, saturating error-distance sum and max error distance over a run.
module loa_error_monitor #(
    parameter int N     = 4,
    parameter int K     = 0,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Start,
    input  logic [CNT_W-1:0] i_NumSamples,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [N-1:0]     i_A,
    input  logic [N-1:0]     i_B,
    input  logic [N-1:0]     i_ApproxSum,
    input  logic             i_ApproxCout,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [CNT_W-1:0] o_SampleCount,
    output logic [CNT_W-1:0] o_ErrCount,
    output logic [ACC_W-1:0] o_ErrDistSum,
    output logic [N:0]       o_MaxErrDist
);

    localparam int EW    = N + 1;
    localparam int SUM_W = ((ACC_W > EW) ? ACC_W : EW) + 1;
    localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({ACC_W{1'b1}});

    // K only describes the monitored adder; reject configurations that cannot exist.
    if (K > N) begin : g_k_range
        $error("K must not exceed N");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ACC_W-1:0] err_sum_q, err_sum_d;
    logic [EW-1:0]    max_ed_q, max_ed_d;
    logic             s1_vld_q, s1_vld_d;
    logic [EW-1:0]    s1_exact_q, s1_exact_d;
    logic [EW-1:0]    s1_approx_q, s1_approx_d;
    logic             drain_cnt_q, drain_cnt_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic [EW-1:0]    ed;
    logic [SUM_W-1:0] sum_ext;

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        err_sum_d    = err_sum_q;
        max_ed_d     = max_ed_q;
        s1_exact_d   = s1_exact_q;
        s1_approx_d  = s1_approx_q;
        drain_cnt_d  = drain_cnt_q;

        accept   = i_Valid && ready_q;
        s1_vld_d = accept;
        if (accept) begin
            s1_exact_d   = {1'b0, i_A} + {1'b0, i_B};
            s1_approx_d  = {i_ApproxCout, i_ApproxSum};
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
        end

        // Stage 2: fold the registered sample into the statistics.
        ed      = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                              : (s1_approx_q - s1_exact_q);
        sum_ext = SUM_W'(err_sum_q) + SUM_W'(ed);
        if (s1_vld_q) begin
            err_cnt_d = err_cnt_q + CNT_W'(ed != '0);
            err_sum_d = (sum_ext > ACC_MAX) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
            if (ed > max_ed_q) begin
                max_ed_d = ed;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_Start) begin
                    target_d     = i_NumSamples;
                    sample_cnt_d = '0;
                    err_cnt_d    = '0;
                    err_sum_d    = '0;
                    max_ed_d     = '0;
                    s1_vld_d     = 1'b0;
                    state_d      = (i_NumSamples == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && (sample_cnt_d == target_q)) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_RUN);
        busy_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q      <= ST_IDLE;
            target_q     <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            err_sum_q    <= '0;
            max_ed_q     <= '0;
            s1_vld_q     <= 1'b0;
            s1_exact_q   <= '0;
            s1_approx_q  <= '0;
            drain_cnt_q  <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            err_sum_q    <= err_sum_d;
            max_ed_q     <= max_ed_d;
            s1_vld_q     <= s1_vld_d;
            s1_exact_q   <= s1_exact_d;
            s1_approx_q  <= s1_approx_d;
            drain_cnt_q  <= drain_cnt_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign o_Ready       = ready_q;
    assign o_Busy        = busy_q;
    assign o_Done        = done_q;
    assign o_SampleCount = sample_cnt_q;
    assign o_ErrCount    = err_cnt_q;
    assign o_ErrDistSum  = err_sum_q;
    assign o_MaxErrDist  = max_ed_q;

endmodule

// File: tb/tb_loa_error_monitor.sv
// Randomized bench for loa_error_monitor: two instances (wide and 4-bit accumulator) share stimulus,
// final statistics are compared against a run-level model built from each run's sample list.
module tb_loa_error_monitor;

    localparam int N     = 4;
    localparam int CNT_W = 16;
    localparam int ACC_W = 32;
    localparam int SAT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num = '0;
    logic             valid = 1'b0;
    logic [N-1:0]     a = '0, b = '0, asum = '0;
    logic             acout = 1'b0;

    logic             ready, busy, done;
    logic [CNT_W-1:0] scnt, ecnt;
    logic [ACC_W-1:0] esum;
    logic [N:0]       emax;

    logic             s_ready, s_busy, s_done;
    logic [CNT_W-1:0] s_scnt, s_ecnt;
    logic [SAT_W-1:0] s_esum;
    logic [N:0]       s_emax;

    int n_cmp = 0;
    int n_mis = 0;
    int q_a[$], q_b[$], q_x[$];

    always #5 clk = ~clk;

    loa_error_monitor #(.N(N), .K(2), .CNT_W(CNT_W), .ACC_W(ACC_W)) u_dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start), .i_NumSamples(num),
        .i_Valid(valid), .o_Ready(ready), .i_A(a), .i_B(b),
        .i_ApproxSum(asum), .i_ApproxCout(acout), .o_Busy(busy), .o_Done(done),
        .o_SampleCount(scnt), .o_ErrCount(ecnt), .o_ErrDistSum(esum), .o_MaxErrDist(emax)
    );

    loa_error_monitor #(.N(N), .K(2), .CNT_W(CNT_W), .ACC_W(SAT_W)) u_sat (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start), .i_NumSamples(num),
        .i_Valid(valid), .o_Ready(s_ready), .i_A(a), .i_B(b),
        .i_ApproxSum(asum), .i_ApproxCout(acout), .o_Busy(s_busy), .o_Done(s_done),
        .o_SampleCount(s_scnt), .o_ErrCount(s_ecnt), .o_ErrDistSum(s_esum), .o_MaxErrDist(s_emax)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int err_dist(input int x, input int y, input int approx);
        int exact;
        exact = x + y;
        return (exact > approx) ? exact - approx : approx - exact;
    endfunction

    task automatic drive_junk(input logic v);
        valid = v;
        a     = 4'($urandom);
        b     = 4'($urandom);
        {acout, asum} = 5'($urandom);
    endtask

    task automatic drive_sample(input int idx);
        valid = 1'b1;
        a     = 4'(q_a[idx]);
        b     = 4'(q_b[idx]);
        {acout, asum} = 5'(q_x[idx]);
    endtask

    task automatic fill(input int n, input int mode);
        int x, y, e;
        q_a.delete(); q_b.delete(); q_x.delete();
        for (int i = 0; i < n; i++) begin
            x = $urandom_range(15);
            y = $urandom_range(15);
            e = x + y;
            q_a.push_back(x);
            q_b.push_back(y);
            case (mode)
                0:       q_x.push_back($urandom_range(31));
                1:       q_x.push_back(e);
                default: q_x.push_back((e >= 2) ? e - 2 : e + 2);
            endcase
        end
    endtask

    task automatic push_sample(input int x, input int y, input int approx);
        q_a.push_back(x);
        q_b.push_back(y);
        q_x.push_back(approx);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_ready"}, ready, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_scnt"}, scnt, 0);
        check_eq({tag, "_ecnt"}, ecnt, 0);
        check_eq({tag, "_esum"}, esum, 0);
        check_eq({tag, "_emax"}, emax, 0);
        check_eq({tag, "_sat_esum"}, s_esum, 0);
    endtask

    // Called one time-step after a rising edge; runs the whole measurement held in the queues.
    task automatic do_run(input string tag, input int n, input int bubble_pct);
        int     exp_err, exp_max, ed, idx, iter, sat_max;
        longint exp_sum;
        bit     v;
        exp_err = 0; exp_max = 0; exp_sum = 0;
        sat_max = (1 << SAT_W) - 1;
        for (int i = 0; i < n; i++) begin
            ed = err_dist(q_a[i], q_b[i], q_x[i]);
            if (ed != 0) exp_err++;
            exp_sum += ed;
            if (ed > exp_max) exp_max = ed;
        end

        start = 1'b1;
        num   = 16'(n);
        drive_junk(1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        iter = 0;
        while (idx < n && iter < 400) begin
            v = ($urandom_range(99) >= bubble_pct);
            if (v) drive_sample(idx);
            else   drive_junk(1'b0);
            // Start pulses during a run must be ignored.
            start = ($urandom_range(7) == 0);
            num   = 16'($urandom);
            @(negedge clk);
            check_eq({tag, "_run_ready"}, ready, 1);
            check_eq({tag, "_run_busy"}, busy, 1);
            check_eq({tag, "_run_scnt"}, scnt, idx);
            if (iter == 0) begin
                check_eq({tag, "_clr_ecnt"}, ecnt, 0);
                check_eq({tag, "_clr_esum"}, esum, 0);
                check_eq({tag, "_clr_emax"}, emax, 0);
            end
            if (v) idx++;
            @(posedge clk); #1;
            iter++;
        end
        check_eq({tag, "_accepts"}, idx, n);

        start = 1'b0;
        drive_junk(1'b1);
        @(negedge clk);
        check_eq({tag, "_drain_ready"}, ready, 0);
        check_eq({tag, "_drain_busy"}, busy, 1);
        check_eq({tag, "_drain_done"}, done, 0);
        @(posedge clk); #1;
        drive_junk(1'b1);
        @(negedge clk);
        check_eq({tag, "_drain2_done"}, done, 0);
        check_eq({tag, "_drain2_ready"}, ready, 0);
        @(posedge clk); #1;
        drive_junk(1'b1);
        @(negedge clk);
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_done_busy"}, busy, 0);
        check_eq({tag, "_done_ready"}, ready, 0);
        check_eq({tag, "_scnt"}, scnt, n);
        check_eq({tag, "_ecnt"}, ecnt, exp_err);
        check_eq({tag, "_esum"}, esum, exp_sum);
        check_eq({tag, "_emax"}, emax, exp_max);
        check_eq({tag, "_sat_ecnt"}, s_ecnt, exp_err);
        check_eq({tag, "_sat_esum"}, s_esum, (exp_sum > sat_max) ? sat_max : exp_sum);
        check_eq({tag, "_sat_emax"}, s_emax, exp_max);
        @(posedge clk); #1;
        drive_junk(1'b0);
        @(negedge clk);
        check_eq({tag, "_hold_done"}, done, 1);
        check_eq({tag, "_hold_scnt"}, scnt, n);
        check_eq({tag, "_hold_ecnt"}, ecnt, exp_err);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset held with busy inputs: nothing may start.
        rst_n = 1'b0;
        start = 1'b1;
        num   = 16'd5;
        drive_junk(1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("rst");
        @(posedge clk); #1;
        start = 1'b0;
        valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("post_rst");
        @(posedge clk); #1;

        // Directed: ED 1,1,2,1 back-to-back.
        q_a.delete(); q_b.delete(); q_x.delete();
        push_sample(3, 1, 3);
        push_sample(5, 5, 9);
        push_sample(2, 2, 6);
        push_sample(15, 15, 31);
        do_run("loa", 4, 0);

        // Zero-sample start goes straight to DONE and clears previous stats.
        start = 1'b1;
        num   = '0;
        drive_junk(1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_eq("zero_done", done, 1);
        check_eq("zero_busy", busy, 0);
        check_eq("zero_ecnt", ecnt, 0);
        check_eq("zero_esum", esum, 0);
        check_eq("zero_emax", emax, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive_junk(1'b1);
            @(negedge clk);
            check_eq("zero_ready", ready, 0);
            check_eq("zero_scnt", scnt, 0);
        end
        @(posedge clk); #1;

        q_a.delete(); q_b.delete(); q_x.delete();
        push_sample(7, 8, 16);
        do_run("one", 1, 0);

        q_a.delete(); q_b.delete(); q_x.delete();
        for (int i = 0; i < 3; i++) push_sample(1, 2, 3);
        do_run("exact", 3, 50);

        fill(2, 0);
        do_run("oversup", 2, 0);

        fill(10, 2);
        do_run("sat", 10, 20);

        // Reset in the middle of a run discards everything.
        fill(10, 0);
        start = 1'b1;
        num   = 16'd10;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_sample(i);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_zero("midrst");
        rst_n = 1'b1;
        valid = 1'b0;
        @(posedge clk); #1;

        for (int r = 0; r < 6; r++) begin
            fill($urandom_range(20, 1), $urandom_range(2));
            do_run($sformatf("rnd%0d", r), q_a.size(), $urandom_range(60));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
